// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply address scheduler.
//   state_t : scheduler FSM state encoding
//   src_t   : grant source (instruction fetch or address generator)
//   is_run  : true for the three generator states that have an address pending
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN_A = 3'd1,
        ST_RUN_B = 3'd2,
        ST_RUN_C = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        SRC_IM  = 1'b0,
        SRC_GEN = 1'b1
    } src_t;

    function automatic logic is_run(input state_t s);
        return (s == ST_RUN_A) || (s == ST_RUN_B) || (s == ST_RUN_C);
    endfunction

endpackage

// File: rtl/addr_rr_arb.sv
// Two-requester round-robin arbiter for the address register.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_im     : instruction-fetch request
//   req_gen    : address-generator request
//   gnt_im     : combinational grant to the fetch requester
//   gnt_gen    : combinational grant to the generator
// A lone requester always wins. When both request, the one that lost the
// previous conflict wins. last_grant only moves on a conflict, and reset
// leaves it at the generator so the first conflict goes to the fetch side.
module addr_rr_arb
    import mm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_im,
    input  logic req_gen,
    output logic gnt_im,
    output logic gnt_gen
);

    src_t last_grant;
    logic conflict;

    assign conflict = req_im && req_gen;

    always_comb begin
        gnt_im  = 1'b0;
        gnt_gen = 1'b0;
        if (conflict) begin
            if (last_grant == SRC_GEN) gnt_im  = 1'b1;
            else                       gnt_gen = 1'b1;
        end else begin
            gnt_im  = req_im;
            gnt_gen = req_gen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_GEN;
        end else if (conflict) begin
            last_grant <= gnt_im ? SRC_IM : SRC_GEN;
        end
    end

endmodule

// File: rtl/mm_addr_sched.sv
// Matrix-multiply address scheduler. Walks C = A x B element by element
// (i outer, j inner) and, for each element, emits the A and B operand
// addresses for k = 0..N-1 followed by the C result address. These share one
// registered address port with an instruction-fetch requester.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : one-cycle job launch (accepted in IDLE only)
//   dim_m/dim_n/dim_p    : job dimensions (A MxN, B NxP, C MxP)
//   base_a/base_b/base_c : row-major base addresses
//   im_req, im_addr      : fetch request and address
//   im_gnt               : combinational fetch grant
//   we, dm_addr, addr_out: registered write strobe, space select, address
//   busy, done           : not-idle flag, registered one-cycle completion pulse
//   state_dbg            : current FSM state
// Handshake: a requester holds its request (and address) until the grant is
// seen high in the same cycle; the transfer completes on that clock edge and
// appears on we/addr_out in the following cycle.
module mm_addr_sched
    import mm_pkg::*;
#(
    parameter int data_width = 16,
    parameter int dim_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [dim_width-1:0]  dim_m,
    input  logic [dim_width-1:0]  dim_n,
    input  logic [dim_width-1:0]  dim_p,
    input  logic [data_width-1:0] base_a,
    input  logic [data_width-1:0] base_b,
    input  logic [data_width-1:0] base_c,
    input  logic                  im_req,
    input  logic [data_width-1:0] im_addr,
    output logic                  im_gnt,
    output logic                  we,
    output logic                  dm_addr,
    output logic [data_width-1:0] addr_out,
    output logic                  busy,
    output logic                  done,
    output state_t                state_dbg
);

    localparam logic [dim_width-1:0]  ONE_D = dim_width'(1);
    localparam logic [data_width-1:0] ONE_A = data_width'(1);

    state_t state, state_nxt;

    logic [dim_width-1:0]  m_q, n_q, p_q;
    logic [dim_width-1:0]  i_q, j_q, k_q;
    logic [data_width-1:0] bb_q;
    // row_a = base_a + i*N, col_b = base_b + j; the ptr_* registers are the
    // running operand pointers built from them by repeated addition.
    logic [data_width-1:0] row_a, ptr_a, col_b, ptr_b, ptr_c;
    logic [data_width-1:0] n_ext, p_ext;

    logic                  gen_req, gnt_gen;
    logic [data_width-1:0] gen_addr;
    logic                  k_last, j_last, i_last, any_zero;

    assign n_ext    = data_width'(n_q);
    assign p_ext    = data_width'(p_q);
    assign k_last   = (k_q == n_q - ONE_D);
    assign j_last   = (j_q == p_q - ONE_D);
    assign i_last   = (i_q == m_q - ONE_D);
    assign any_zero = (dim_m == '0) || (dim_n == '0) || (dim_p == '0);

    addr_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_im  (im_req),
        .req_gen (gen_req),
        .gnt_im  (im_gnt),
        .gnt_gen (gnt_gen)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: generator states advance only on their own grant
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = any_zero ? ST_DONE : ST_RUN_A;
            ST_RUN_A: if (gnt_gen) state_nxt = ST_RUN_B;
            ST_RUN_B: if (gnt_gen) state_nxt = k_last ? ST_RUN_C : ST_RUN_A;
            ST_RUN_C: if (gnt_gen) state_nxt = (j_last && i_last) ? ST_DONE : ST_RUN_A;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (state != ST_IDLE);
        gen_req   = is_run(state);
        state_dbg = state;
        case (state)
            ST_RUN_A: gen_addr = ptr_a;
            ST_RUN_B: gen_addr = ptr_b;
            ST_RUN_C: gen_addr = ptr_c;
            default:  gen_addr = '0;
        endcase
    end

    // Loop counters and running pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            n_q   <= '0;
            p_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            bb_q  <= '0;
            row_a <= '0;
            ptr_a <= '0;
            col_b <= '0;
            ptr_b <= '0;
            ptr_c <= '0;
        end else if (state == ST_IDLE && start) begin
            m_q   <= dim_m;
            n_q   <= dim_n;
            p_q   <= dim_p;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            bb_q  <= base_b;
            row_a <= base_a;
            ptr_a <= base_a;
            col_b <= base_b;
            ptr_b <= base_b;
            ptr_c <= base_c;
        end else if (gnt_gen) begin
            if (state == ST_RUN_B) begin
                // Pointers are left alone on the last k; the C step rewinds them.
                if (k_last) begin
                    k_q <= '0;
                end else begin
                    k_q   <= k_q + ONE_D;
                    ptr_a <= ptr_a + ONE_A;
                    ptr_b <= ptr_b + p_ext;
                end
            end else if (state == ST_RUN_C) begin
                // C is row-major in the same i/j order, so it simply counts up.
                ptr_c <= ptr_c + ONE_A;
                if (j_last) begin
                    j_q   <= '0;
                    col_b <= bb_q;
                    ptr_b <= bb_q;
                    if (!i_last) begin
                        i_q   <= i_q + ONE_D;
                        row_a <= row_a + n_ext;
                        ptr_a <= row_a + n_ext;
                    end
                end else begin
                    j_q   <= j_q + ONE_D;
                    col_b <= col_b + ONE_A;
                    ptr_b <= col_b + ONE_A;
                    ptr_a <= row_a;
                end
            end
        end
    end

    // Registered address port and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we       <= 1'b0;
            dm_addr  <= 1'b0;
            addr_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            if (im_gnt) begin
                we       <= 1'b1;
                dm_addr  <= 1'b0;
                addr_out <= im_addr;
            end else if (gnt_gen) begin
                we       <= 1'b1;
                dm_addr  <= 1'b1;
                addr_out <= gen_addr;
            end else begin
                we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mm_addr_sched.sv
// Directed bench for mm_addr_sched. A nested-loop model of the matrix walk
// fills an expected queue of data-memory addresses; a monitor compares every
// write against it, and literal address lists pin the model.
module tb_mm_addr_sched;
    import mm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  dim_m, dim_n, dim_p;
    logic [15:0] base_a, base_b, base_c;
    logic        im_req;
    logic [15:0] im_addr;
    logic        im_gnt, we, dm_addr, busy, done;
    logic [15:0] addr_out;
    state_t      state_dbg;

    mm_addr_sched #(.data_width(16), .dim_width(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dim_m     (dim_m),
        .dim_n     (dim_n),
        .dim_p     (dim_p),
        .base_a    (base_a),
        .base_b    (base_b),
        .base_c    (base_c),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_gnt    (im_gnt),
        .we        (we),
        .dm_addr   (dm_addr),
        .addr_out  (addr_out),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] dm_log[$];
    int          dm_cyc[$];
    int          im_cyc[$];
    int          we_cnt, done_cnt, busy_cnt, done_cyc, start_cyc;
    bit          mon_en = 1'b0;
    logic [15:0] exp_im = 16'h0040;

    logic [15:0] lit1 [5]  = '{16'h0100, 16'h0200, 16'h0101, 16'h0201, 16'h0300};
    logic [15:0] lit2 [10] = '{16'h0100, 16'h0200, 16'h0101, 16'h0202, 16'h0300,
                               16'h0100, 16'h0201, 16'h0101, 16'h0203, 16'h0301};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] log_at(input int i);
        if (i < dm_log.size()) return dm_log[i];
        return 16'hxxxx;
    endfunction

    function automatic int dcyc_at(input int i);
        if (i < dm_cyc.size()) return dm_cyc[i];
        return -1000;
    endfunction

    function automatic int icyc_at(input int i);
        if (i < im_cyc.size()) return im_cyc[i];
        return -1000;
    endfunction

    // ---------------- model ----------------
    task automatic push_model(input int m, input int n, input int p,
                              input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc);
        for (int i = 0; i < m; i++)
            for (int j = 0; j < p; j++) begin
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back(16'(int'(ba) + i * n + k));
                    exp_q.push_back(16'(int'(bb) + k * p + j));
                end
                exp_q.push_back(16'(int'(bc) + i * p + j));
            end
    endtask

    // ---------------- monitor / compare ----------------
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (we) begin
                we_cnt++;
                if (dm_addr) begin
                    dm_log.push_back(addr_out);
                    dm_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dm_extra act=%h req=none", addr_out);
                    end else begin
                        check("dm_addr", addr_out, exp_q.pop_front());
                    end
                end else begin
                    im_cyc.push_back(cyc);
                    check("im_addr", addr_out, exp_im);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        dm_log.delete();
        dm_cyc.delete();
        im_cyc.delete();
        we_cnt   = 0;
        done_cnt = 0;
        busy_cnt = 0;
        done_cyc = -1000;
    endtask

    task automatic start_job(input int m, input int n, input int p,
                             input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                             input bit with_im);
        exp_q.delete();
        clear_logs();
        push_model(m, n, p, ba, bb, bc);
        @(posedge clk);
        #1;
        dim_m  = 8'(m);
        dim_n  = 8'(n);
        dim_p  = 8'(p);
        base_a = ba;
        base_b = bb;
        base_c = bc;
        start  = 1'b1;
        if (with_im) im_req = 1'b1;
        start_cyc = cyc;
        mon_en = 1'b1;
        @(negedge clk);
        if (with_im) check("im_gnt_idle", im_gnt, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        check({name, "_done_seen"}, seen, 1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        dim_m   = '0;
        dim_n   = '0;
        dim_p   = '0;
        base_a  = '0;
        base_b  = '0;
        base_c  = '0;
        im_req  = 1'b0;
        im_addr = 16'h0040;

        // Reset state
        #3;
        check("rst_we", we, 0);
        check("rst_dm_addr", dm_addr, 0);
        check("rst_addr_out", addr_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_im_gnt", im_gnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // T1: M=1 N=2 P=1, no fetch traffic
        start_job(1, 2, 1, 16'h0100, 16'h0200, 16'h0300, 1'b0);
        wait_done("t1");
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_we_cnt", we_cnt, 5);
        check("t1_done_cnt", done_cnt, 1);
        for (int i = 0; i < 5; i++) check($sformatf("t1_lit%0d", i), log_at(i), lit1[i]);
        check("t1_first_write", dcyc_at(0), start_cyc + 2);
        check("t1_consecutive", dcyc_at(4) - dcyc_at(0), 4);
        check("t1_done_after_last", done_cyc - dcyc_at(4), 1);

        // T3: same job with a fetch request held throughout
        start_job(1, 2, 1, 16'h0100, 16'h0200, 16'h0300, 1'b1);
        wait_done("t3");
        im_req = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_queue_empty", exp_q.size(), 0);
        check("t3_dm_cnt", dm_log.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("t3_lit%0d", i), log_at(i), lit1[i]);
        check("t3_im_first", icyc_at(1), start_cyc + 2);
        check("t3_first_dm", dcyc_at(0), start_cyc + 3);
        for (int i = 1; i < 5; i++) check($sformatf("t3_alt%0d", i), dcyc_at(i) - dcyc_at(i - 1), 2);
        check("t3_done_cnt", done_cnt, 1);

        // T4: zero dimension
        start_job(2, 0, 3, 16'h0100, 16'h0200, 16'h0300, 1'b0);
        wait_done("t4");
        check("t4_we_cnt", we_cnt, 0);
        check("t4_done_time", done_cyc - start_cyc, 2);
        check("t4_busy_cnt", busy_cnt, 1);
        check("t4_done_cnt", done_cnt, 1);

        // T5: reset during RUN_B of the 2x2x2 job
        start_job(2, 2, 2, 16'h0100, 16'h0200, 16'h0300, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t5_in_run_b", state_dbg, ST_RUN_B);
        check("t5_we_before", we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_we", we, 0);
        check("t5_rst_dm_addr", dm_addr, 0);
        check("t5_rst_addr_out", addr_out, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (6) @(negedge clk);
        check("t5_no_we_after", we_cnt, 0);
        check("t5_no_done_after", done_cnt, 0);
        check("t5_idle_after", busy_cnt, 0);

        // T2: full 2x2x2 job after the aborted one
        start_job(2, 2, 2, 16'h0100, 16'h0200, 16'h0300, 1'b0);
        wait_done("t2");
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_dm_cnt", dm_log.size(), 20);
        check("t2_we_cnt", we_cnt, 20);
        for (int i = 0; i < 10; i++) check($sformatf("t2_lit%0d", i), log_at(i), lit2[i]);
        check("t2_done_cnt", done_cnt, 1);

        // T6: A address wraps past 0xFFFF
        start_job(1, 2, 1, 16'hFFFF, 16'h0200, 16'h0300, 1'b0);
        wait_done("t6");
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_a0", log_at(0), 16'hFFFF);
        check("t6_a1_wrap", log_at(2), 16'h0000);
        check("t6_we_cnt", we_cnt, 5);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
